// File: rtl/ysyx_rou_pkg.sv
// Shared types and sizes for the reorder-buffer retire queue.
package ysyx_rou_pkg;

    localparam int unsigned ROU_XLEN   = 32;
    localparam int unsigned ROU_DEPTH  = 8;
    localparam int unsigned ROU_TW     = $clog2(ROU_DEPTH);
    localparam int unsigned ROU_KIND_W = 6;

    typedef struct packed {
        logic ebreak;
        logic fence_i;
        logic fence_time;
        logic is_br;
        logic is_jal;
        logic is_jalr;
    } rou_kind_t;

    typedef struct packed {
        logic [ROU_XLEN-1:0] pc;
        logic [ROU_XLEN-1:0] pnpc;
        logic [ROU_XLEN-1:0] npc;
        logic [31:0]         inst;
        logic [4:0]          rd;
        rou_kind_t           kind;
        logic                btaken;
        logic                valid;
        logic                done;
    } rou_entry_t;

    typedef struct packed {
        logic [ROU_XLEN-1:0] pc;
        logic [ROU_XLEN-1:0] npc;
        logic [31:0]         inst;
        logic [4:0]          rd;
        logic                ben;
        logic                jen;
        logic                jren;
        logic                btaken;
        logic                ebreak;
        logic                fence_i;
        logic                fence_time;
        logic                time_trap;
        logic                flush_pipe;
    } rou_rc_t;

endpackage

// File: rtl/ysyx_rou_retire_if.sv
// Dispatch / writeback / retire bundle between the pipeline and the retire queue.
interface ysyx_rou_retire_if;
    import ysyx_rou_pkg::*;

    logic                  disp_valid;
    logic                  disp_ready;
    logic [ROU_TW-1:0]     disp_tag;
    logic [ROU_XLEN-1:0]   disp_pc;
    logic [ROU_XLEN-1:0]   disp_pnpc;
    logic [31:0]           disp_inst;
    logic [4:0]            disp_rd;
    logic [ROU_KIND_W-1:0] disp_kind;

    logic                  wb_valid;
    logic [ROU_TW-1:0]     wb_tag;
    logic [ROU_XLEN-1:0]   wb_npc;
    logic                  wb_btaken;

    logic                  irq_pending;

    logic                  rc_valid;
    logic [ROU_XLEN-1:0]   rc_pc;
    logic [ROU_XLEN-1:0]   rc_npc;
    logic [31:0]           rc_inst;
    logic [4:0]            rc_rd;
    logic                  rc_ben;
    logic                  rc_jen;
    logic                  rc_jren;
    logic                  rc_btaken;
    logic                  rc_ebreak;
    logic                  rc_fence_i;
    logic                  rc_fence_time;
    logic                  rc_time_trap;
    logic                  rc_flush_pipe;

    modport master (
        output disp_valid, disp_pc, disp_pnpc, disp_inst, disp_rd, disp_kind,
        output wb_valid, wb_tag, wb_npc, wb_btaken, irq_pending,
        input  disp_ready, disp_tag,
        input  rc_valid, rc_pc, rc_npc, rc_inst, rc_rd, rc_ben, rc_jen, rc_jren,
        input  rc_btaken, rc_ebreak, rc_fence_i, rc_fence_time, rc_time_trap, rc_flush_pipe
    );

    modport slave (
        input  disp_valid, disp_pc, disp_pnpc, disp_inst, disp_rd, disp_kind,
        input  wb_valid, wb_tag, wb_npc, wb_btaken, irq_pending,
        output disp_ready, disp_tag,
        output rc_valid, rc_pc, rc_npc, rc_inst, rc_rd, rc_ben, rc_jen, rc_jren,
        output rc_btaken, rc_ebreak, rc_fence_i, rc_fence_time, rc_time_trap, rc_flush_pipe
    );

endinterface

// File: rtl/ysyx_rou_retire.sv
// In-order retire queue: allocates on dispatch, completes on writeback,
// retires one registered record per cycle from the head, flushes on redirect.
module ysyx_rou_retire
    import ysyx_rou_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    ysyx_rou_retire_if.slave bus
);

    typedef logic [ROU_TW:0] ptr_t;

    ptr_t       head_q, head_d;
    ptr_t       tail_q, tail_d;
    rou_entry_t ent_q [ROU_DEPTH];
    rou_entry_t ent_d [ROU_DEPTH];
    rou_rc_t    rc_q, rc_d;
    logic       rc_valid_q, rc_valid_d;

    logic [ROU_TW-1:0] head_idx;
    logic [ROU_TW-1:0] tail_idx;
    rou_entry_t        head_ent;
    rou_kind_t         disp_kind;
    logic              full_c;
    logic              redirect_c;
    logic              fire_c;
    logic              retire_c;
    logic              flush_c;

    assign head_idx  = head_q[ROU_TW-1:0];
    assign tail_idx  = tail_q[ROU_TW-1:0];
    assign head_ent  = ent_q[head_idx];
    assign disp_kind = rou_kind_t'(bus.disp_kind);

    assign full_c     = (head_idx == tail_idx) && (head_q[ROU_TW] != tail_q[ROU_TW]);
    // rc_flush_pipe holds after the redirect; only the cycle it is fresh blocks dispatch
    assign redirect_c = rc_valid_q & rc_q.flush_pipe;
    assign fire_c     = bus.disp_valid & bus.disp_ready;
    assign retire_c   = head_ent.valid & head_ent.done;
    assign flush_c    = retire_c & ((head_ent.npc != head_ent.pnpc)
                                    | head_ent.kind.fence_i
                                    | bus.irq_pending);

    assign bus.disp_ready = ~full_c & ~redirect_c;
    assign bus.disp_tag   = tail_idx;

    // Next-state: writeback, retire, dispatch, then flush overrides everything
    always_comb begin
        ent_d      = ent_q;
        head_d     = head_q;
        tail_d     = tail_q;
        rc_d       = rc_q;
        rc_valid_d = 1'b0;

        if (bus.wb_valid && ent_q[bus.wb_tag].valid) begin
            ent_d[bus.wb_tag].done   = 1'b1;
            ent_d[bus.wb_tag].npc    = bus.wb_npc;
            ent_d[bus.wb_tag].btaken = bus.wb_btaken;
        end

        if (retire_c) begin
            rc_valid_d         = 1'b1;
            rc_d.pc            = head_ent.pc;
            rc_d.npc           = head_ent.npc;
            rc_d.inst          = head_ent.inst;
            rc_d.rd            = head_ent.rd;
            rc_d.ben           = head_ent.kind.is_br;
            rc_d.jen           = head_ent.kind.is_jal;
            rc_d.jren          = head_ent.kind.is_jalr;
            rc_d.btaken        = head_ent.btaken & head_ent.kind.is_br;
            rc_d.ebreak        = head_ent.kind.ebreak;
            rc_d.fence_i       = head_ent.kind.fence_i;
            rc_d.fence_time    = head_ent.kind.fence_time;
            rc_d.time_trap     = bus.irq_pending;
            rc_d.flush_pipe    = flush_c;
            ent_d[head_idx].valid = 1'b0;
            ent_d[head_idx].done  = 1'b0;
            head_d             = head_q + ptr_t'(1);
        end

        if (fire_c) begin
            ent_d[tail_idx].pc     = bus.disp_pc;
            ent_d[tail_idx].pnpc   = bus.disp_pnpc;
            ent_d[tail_idx].npc    = '0;
            ent_d[tail_idx].inst   = bus.disp_inst;
            ent_d[tail_idx].rd     = bus.disp_rd;
            ent_d[tail_idx].kind   = disp_kind;
            ent_d[tail_idx].btaken = 1'b0;
            ent_d[tail_idx].valid  = 1'b1;
            ent_d[tail_idx].done   = 1'b0;
            tail_d                 = tail_q + ptr_t'(1);
        end

        if (flush_c) begin
            for (int unsigned i = 0; i < ROU_DEPTH; i++) begin
                ent_d[i].valid = 1'b0;
                ent_d[i].done  = 1'b0;
            end
            head_d = '0;
            tail_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            rc_q       <= '0;
            rc_valid_q <= 1'b0;
            for (int unsigned i = 0; i < ROU_DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            rc_q       <= rc_d;
            rc_valid_q <= rc_valid_d;
            for (int unsigned i = 0; i < ROU_DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    assign bus.rc_valid      = rc_valid_q;
    assign bus.rc_pc         = rc_q.pc;
    assign bus.rc_npc        = rc_q.npc;
    assign bus.rc_inst       = rc_q.inst;
    assign bus.rc_rd         = rc_q.rd;
    assign bus.rc_ben        = rc_q.ben;
    assign bus.rc_jen        = rc_q.jen;
    assign bus.rc_jren       = rc_q.jren;
    assign bus.rc_btaken     = rc_q.btaken;
    assign bus.rc_ebreak     = rc_q.ebreak;
    assign bus.rc_fence_i    = rc_q.fence_i;
    assign bus.rc_fence_time = rc_q.fence_time;
    assign bus.rc_time_trap  = rc_q.time_trap;
    assign bus.rc_flush_pipe = rc_q.flush_pipe;

endmodule

// File: tb/tb_ysyx_rou_retire.sv
// Directed bench for ysyx_rou_retire with an in-order queue model checked every cycle.
module tb_ysyx_rou_retire;
    import ysyx_rou_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ysyx_rou_retire_if bus();

    ysyx_rou_retire dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pnpc;
        logic [31:0] npc;
        logic [31:0] inst;
        logic [4:0]  rd;
        logic [5:0]  kind;
        logic        done;
        logic        btaken;
        int          tag;
    } m_ent_t;

    m_ent_t      mq[$];
    int          m_next_tag = 0;
    bit          m_live = 1'b0;
    logic        e_valid, e_ben, e_jen, e_jren, e_btaken, e_ebreak;
    logic        e_fi, e_ft, e_tt, e_flush;
    logic [31:0] e_pc, e_npc, e_inst;
    logic [4:0]  e_rd;

    // Model: program-order list of in-flight instructions; kind = {ebreak,fence_i,fence_time,br,jal,jalr}
    always @(posedge clock) begin
        bit     ready, fire, ret;
        m_ent_t h, n;
        if (reset) begin
            mq.delete();
            m_next_tag = 0;
            {e_valid, e_ben, e_jen, e_jren, e_btaken, e_ebreak, e_fi, e_ft, e_tt, e_flush} = '0;
            e_pc = '0; e_npc = '0; e_inst = '0; e_rd = '0;
            m_live = 1'b1;
        end else if (m_live) begin
            ready = (mq.size() < ROU_DEPTH) && !(e_valid && e_flush);
            fire  = bus.disp_valid && ready;
            ret   = (mq.size() > 0) && mq[0].done;
            h     = '{default: '0};
            if (ret) h = mq[0];
            if (bus.wb_valid) begin
                foreach (mq[i]) begin
                    if (mq[i].tag == int'(bus.wb_tag)) begin
                        mq[i].done   = 1'b1;
                        mq[i].npc    = bus.wb_npc;
                        mq[i].btaken = bus.wb_btaken;
                    end
                end
            end
            e_valid = 1'b0;
            if (ret) begin
                void'(mq.pop_front());
                e_valid  = 1'b1;
                e_pc     = h.pc;
                e_npc    = h.npc;
                e_inst   = h.inst;
                e_rd     = h.rd;
                e_ebreak = h.kind[5];
                e_fi     = h.kind[4];
                e_ft     = h.kind[3];
                e_ben    = h.kind[2];
                e_jen    = h.kind[1];
                e_jren   = h.kind[0];
                e_btaken = h.btaken & h.kind[2];
                e_tt     = bus.irq_pending;
                e_flush  = (h.npc != h.pnpc) | h.kind[4] | bus.irq_pending;
            end
            if (ret && e_flush) begin
                mq.delete();
                m_next_tag = 0;
            end else if (fire) begin
                n.pc = bus.disp_pc; n.pnpc = bus.disp_pnpc; n.npc = '0;
                n.inst = bus.disp_inst; n.rd = bus.disp_rd; n.kind = bus.disp_kind;
                n.done = 1'b0; n.btaken = 1'b0; n.tag = m_next_tag;
                mq.push_back(n);
                m_next_tag = (m_next_tag + 1) % ROU_DEPTH;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clock) begin
        logic [110:0] got, exp;
        logic         exp_ready;
        if (m_live) begin
            got = {bus.rc_valid, bus.rc_pc, bus.rc_npc, bus.rc_inst, bus.rc_rd,
                   bus.rc_ben, bus.rc_jen, bus.rc_jren, bus.rc_btaken, bus.rc_ebreak,
                   bus.rc_fence_i, bus.rc_fence_time, bus.rc_time_trap, bus.rc_flush_pipe};
            exp = {e_valid, e_pc, e_npc, e_inst, e_rd, e_ben, e_jen, e_jren, e_btaken,
                   e_ebreak, e_fi, e_ft, e_tt, e_flush};
            n_vec++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL rc_record @%0t: got %h expected %h", $time, got, exp);
            end
            exp_ready = (mq.size() < ROU_DEPTH) && !(e_valid && e_flush);
            n_vec++;
            if ({bus.disp_ready, bus.disp_tag} !== {exp_ready, ROU_TW'(m_next_tag)}) begin
                n_bad++;
                $display("FAIL disp_ready_tag @%0t: got %b/%0d expected %b/%0d", $time,
                         bus.disp_ready, bus.disp_tag, exp_ready, m_next_tag);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.disp_valid  = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.irq_pending = 1'b0;
    endtask

    task automatic disp(input logic [31:0] pc, input logic [31:0] pnpc, input logic [31:0] inst,
                        input logic [4:0] rd, input logic [5:0] kind);
        bus.disp_valid = 1'b1;
        bus.disp_pc    = pc;
        bus.disp_pnpc  = pnpc;
        bus.disp_inst  = inst;
        bus.disp_rd    = rd;
        bus.disp_kind  = kind;
    endtask

    task automatic wb(input int tag, input logic [31:0] npc, input logic bt);
        bus.wb_valid  = 1'b1;
        bus.wb_tag    = ROU_TW'(tag);
        bus.wb_npc    = npc;
        bus.wb_btaken = bt;
    endtask

    initial begin
        idle();
        disp(32'h0, 32'h0, 32'h0, 5'd0, 6'd0);
        bus.disp_valid = 1'b0;
        wb(0, 32'h0, 1'b0);
        bus.wb_valid = 1'b0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;

        // reset state
        chk("rst_ready", 32'(bus.disp_ready), 32'd1);
        chk("rst_rc_valid", 32'(bus.rc_valid), 32'd0);
        chk("rst_tag", 32'(bus.disp_tag), 32'd0);
        chk("rst_rc_pc", bus.rc_pc, 32'd0);

        // straight-line: dispatch c1, wb c3, retire visible c5
        disp(32'h8000_0000, 32'h8000_0004, 32'h0050_0293, 5'd5, 6'b000000); step();
        idle(); step();
        wb(0, 32'h8000_0004, 1'b0); step();
        chk("wb_not_yet", 32'(bus.rc_valid), 32'd0);
        idle(); step();
        chk("sl_valid", 32'(bus.rc_valid), 32'd1);
        chk("sl_pc", bus.rc_pc, 32'h8000_0000);
        chk("sl_rd", 32'(bus.rc_rd), 32'd5);
        chk("sl_flush", 32'(bus.rc_flush_pipe), 32'd0);
        step();
        chk("sl_pulse", 32'(bus.rc_valid), 32'd0);
        chk("sl_hold_pc", bus.rc_pc, 32'h8000_0000);

        // out-of-order completion, in-order retire
        reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            disp(32'(32'h100 + 4 * i), 32'(32'h104 + 4 * i), 32'h0000_0013, 5'(i + 1), 6'd0);
            step();
        end
        idle();
        wb(2, 32'h10c, 1'b0); step();
        wb(1, 32'h108, 1'b0); step();
        wb(0, 32'h104, 1'b0); step();
        chk("ooo_wait", 32'(bus.rc_valid), 32'd0);
        idle(); step();
        chk("ooo_pc0", bus.rc_pc, 32'h100);
        step();
        chk("ooo_pc1", bus.rc_pc, 32'h104);
        step();
        chk("ooo_pc2", bus.rc_pc, 32'h108);
        chk("ooo_v2", 32'(bus.rc_valid), 32'd1);
        step();
        chk("ooo_end", 32'(bus.rc_valid), 32'd0);

        // full queue, 9th dropped, no enqueue while full even when retiring
        reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            disp(32'(32'h200 + 4 * i), 32'(32'h204 + 4 * i), 32'h0000_0013, 5'd1, 6'd0);
            step();
        end
        chk("full_ready", 32'(bus.disp_ready), 32'd0);
        disp(32'h300, 32'h304, 32'h0000_0013, 5'd2, 6'd0);
        wb(0, 32'h204, 1'b0); step();
        chk("full_ready2", 32'(bus.disp_ready), 32'd0);
        bus.wb_valid = 1'b0; step();
        chk("full_ret_pc", bus.rc_pc, 32'h200);
        chk("full_ready_again", 32'(bus.disp_ready), 32'd1);
        chk("full_tag", 32'(bus.disp_tag), 32'd0);
        idle();
        for (int i = 1; i < 8; i++) begin
            wb(i, 32'(32'h204 + 4 * i), 1'b0);
            step();
        end
        idle();
        disp(32'h400, 32'h404, 32'h0000_0013, 5'd3, 6'd0); step();
        idle(); wb(0, 32'h404, 1'b0); step();
        idle();
        repeat (10) step();
        chk("drain_last_pc", bus.rc_pc, 32'h400);
        chk("drain_tag", 32'(bus.disp_tag), 32'd1);

        // branch mispredict flushes younger entries
        reset = 1'b1; step(); reset = 1'b0;
        disp(32'h80, 32'h100, 32'h0000_0063, 5'd0, 6'b000100); step();
        disp(32'h84, 32'h88, 32'h0000_0013, 5'd1, 6'd0); step();
        disp(32'h88, 32'h8c, 32'h0000_0013, 5'd2, 6'd0); step();
        idle(); wb(0, 32'h200, 1'b1); step();
        wb(1, 32'h88, 1'b0); step();
        chk("mp_valid", 32'(bus.rc_valid), 32'd1);
        chk("mp_ben", 32'(bus.rc_ben), 32'd1);
        chk("mp_btaken", 32'(bus.rc_btaken), 32'd1);
        chk("mp_flush", 32'(bus.rc_flush_pipe), 32'd1);
        chk("mp_npc", bus.rc_npc, 32'h200);
        chk("mp_ready", 32'(bus.disp_ready), 32'd0);
        idle(); disp(32'h500, 32'h504, 32'h0000_0013, 5'd4, 6'd0); step();
        chk("mp_tag", 32'(bus.disp_tag), 32'd0);
        chk("mp_ready_back", 32'(bus.disp_ready), 32'd1);
        step();
        idle();
        chk("mp_tag_next", 32'(bus.disp_tag), 32'd1);
        repeat (3) step();

        // mid-operation reset, then timer trap with concurrent dispatch
        reset = 1'b1; step(); reset = 1'b0;
        chk("midrst_valid", 32'(bus.rc_valid), 32'd0);
        chk("midrst_tag", 32'(bus.disp_tag), 32'd0);
        disp(32'h600, 32'h604, 32'h0000_0013, 5'd3, 6'd0); step();
        idle(); wb(0, 32'h604, 1'b0); step();
        idle(); bus.irq_pending = 1'b1;
        disp(32'h700, 32'h704, 32'h0000_0013, 5'd6, 6'd0); step();
        chk("tt_trap", 32'(bus.rc_time_trap), 32'd1);
        chk("tt_flush", 32'(bus.rc_flush_pipe), 32'd1);
        chk("tt_pc", bus.rc_pc, 32'h600);
        chk("tt_ready", 32'(bus.disp_ready), 32'd0);
        bus.irq_pending = 1'b0; step();
        chk("tt_tag", 32'(bus.disp_tag), 32'd0);
        idle(); wb(0, 32'h704, 1'b0); step();
        idle(); repeat (4) step();
        chk("tt_no_ghost", 32'(bus.rc_valid), 32'd0);

        // fence.i redirect, then correctly predicted jal and ebreak/fence_time
        disp(32'h900, 32'h904, 32'h0000_100f, 5'd0, 6'b010000); step();
        idle(); wb(0, 32'h904, 1'b0); step();
        idle(); step();
        chk("fi_flag", 32'(bus.rc_fence_i), 32'd1);
        chk("fi_flush", 32'(bus.rc_flush_pipe), 32'd1);
        chk("fi_trap", 32'(bus.rc_time_trap), 32'd0);
        step();
        disp(32'ha00, 32'hb00, 32'h1000_006f, 5'd1, 6'b000010); step();
        disp(32'hb00, 32'hb04, 32'h0010_0073, 5'd0, 6'b101000); step();
        idle(); wb(1, 32'hb04, 1'b0); step();
        wb(0, 32'hb00, 1'b0); step();
        idle(); step();
        chk("jal_jen", 32'(bus.rc_jen), 32'd1);
        chk("jal_flush", 32'(bus.rc_flush_pipe), 32'd0);
        step();
        chk("eb_ebreak", 32'(bus.rc_ebreak), 32'd1);
        chk("eb_ftime", 32'(bus.rc_fence_time), 32'd1);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
